mmio_port_ctrl: RTL

Parametrised memory-mapped I/O port controller on the CPU data bus, alongside the data RAM. Replaces the fixed single-input/single-output (1-bit strobe + 30-bit data) port pair with NUM_IN input and NUM_OUT output channels. Input channels are synchronised and edge-captured with a ready/overrun flag per channel. Output channels use a valid/ack handshake with a drop flag, and the CPU polls all flags through one status register.

---
 rtl/mmio_port_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mmio_port_ctrl.sv
// mmio_port_ctrl: memory-mapped I/O port controller on the CPU data bus.
// NUM_IN input channels are synchronised and edge-captured into holding
// registers with ready/overrun flags. NUM_OUT output channels drive a
// valid/ack handshake with a drop flag. All flags are polled through one
// STATUS word at offset 0x00 of a 256-byte window.
module mmio_port_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                NUM_IN      = 2,
  parameter int                NUM_OUT     = 2,
  parameter int                IN_W        = 30,
  parameter int                OUT_W       = 30,
  parameter logic [DATA_W-1:0] BASE_ADDR   = 32'hFFFF_F000,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     lw_en,
  input  logic                     sw_en,
  output logic                     hit,
  output logic [DATA_W-1:0]        rdata,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*IN_W-1:0]   in_data,
  output logic [NUM_OUT-1:0]       out_valid,
  output logic [NUM_OUT*OUT_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]       out_ack
);

  // Word indices inside the window: IN_DATA[i] at 0x10+4i, OUT_DATA[j] at 0x40+4j.
  localparam int IN_WORD  = 4;
  localparam int OUT_WORD = 16;

  logic [5:0]                        word;
  logic [DATA_W-1:0]                 status;
  logic [DATA_W-1:0]                 load_val;
  logic                              unused_bits;

  logic [NUM_IN-1:0][SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0]            flush_q;
  logic [NUM_IN-1:0]                 prev_q;
  logic [NUM_IN-1:0]                 armed_q;
  logic [NUM_IN-1:0][IN_W-1:0]       hold_q;
  logic [NUM_IN-1:0]                 in_ready;
  logic [NUM_IN-1:0]                 in_ovr;
  logic [NUM_OUT-1:0]                out_drop;

  logic [NUM_IN-1:0]                 capture;
  logic [NUM_IN-1:0]                 rd_in;
  logic [NUM_IN-1:0]                 clr_ovr;
  logic [NUM_OUT-1:0]                wr_out;
  logic [NUM_OUT-1:0]                clr_drop;

  // Address decode: window match on the upper bits, word offset relative to the base.
  assign hit         = (addr[DATA_W-1:8] == BASE_ADDR[DATA_W-1:8]);
  assign word        = addr[7:2] - BASE_ADDR[7:2];
  assign unused_bits = ^{addr[1:0], wdata};

  // Per-channel strobes derived from the bus access and the synchronised inputs.
  always_comb begin
    capture  = '0;
    rd_in    = '0;
    clr_ovr  = '0;
    wr_out   = '0;
    clr_drop = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      capture[i] = sync_q[i][SYNC_STAGES-1] & ~prev_q[i] & armed_q[i];
      rd_in[i]   = lw_en & hit & (word == 6'(IN_WORD + i));
      clr_ovr[i] = sw_en & hit & (word == 6'd0) & wdata[8+i];
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      wr_out[j]   = sw_en & hit & (word == 6'(OUT_WORD + j));
      clr_drop[j] = sw_en & hit & (word == 6'd0) & wdata[24+j];
    end
  end

  // Load data selection from pre-edge state, so a simultaneous store is not visible.
  always_comb begin
    status   = '0;
    load_val = '0;
    status[NUM_IN-1:0]    = in_ready;
    status[8 +: NUM_IN]   = in_ovr;
    status[16 +: NUM_OUT] = out_valid;
    status[24 +: NUM_OUT] = out_drop;
    if (word == 6'd0) begin
      load_val = status;
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (word == 6'(IN_WORD + i)) begin
        load_val = DATA_W'(hold_q[i]);
      end
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (word == 6'(OUT_WORD + j)) begin
        load_val = DATA_W'(out_data[j*OUT_W +: OUT_W]);
      end
    end
  end

  // Registered load data; only loads that hit the window update it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (lw_en && hit) begin
      rdata <= load_val;
    end
  end

  // Input channels: synchroniser, edge capture, ready/overrun bookkeeping.
  // flush_q marks when the synchroniser holds genuinely sampled values after
  // reset; a channel is armed only after seeing a real low, so a line held
  // high across reset release never produces a capture until it drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      flush_q  <= '0;
      prev_q   <= '0;
      armed_q  <= '0;
      hold_q   <= '0;
      in_ready <= '0;
      in_ovr   <= '0;
    end else begin
      flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      for (int i = 0; i < NUM_IN; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], in_valid[i]};
        prev_q[i] <= sync_q[i][SYNC_STAGES-1];
        if (flush_q[SYNC_STAGES-1] && !sync_q[i][SYNC_STAGES-1]) begin
          armed_q[i] <= 1'b1;
        end
        if (capture[i]) begin
          hold_q[i]   <= in_data[i*IN_W +: IN_W];
          in_ready[i] <= 1'b1;
        end else if (rd_in[i]) begin
          in_ready[i] <= 1'b0;
        end
        if (capture[i] && in_ready[i] && !rd_in[i]) begin
          in_ovr[i] <= 1'b1;
        end else if (clr_ovr[i]) begin
          in_ovr[i] <= 1'b0;
        end
      end
    end
  end

  // Output channels: store-to-valid handshake with ack, drop flag on busy stores.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_drop  <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (wr_out[j] && (!out_valid[j] || out_ack[j])) begin
          out_data[j*OUT_W +: OUT_W] <= wdata[OUT_W-1:0];
          out_valid[j]               <= 1'b1;
        end else if (out_ack[j]) begin
          out_valid[j] <= 1'b0;
        end
        if (wr_out[j] && out_valid[j] && !out_ack[j]) begin
          out_drop[j] <= 1'b1;
        end else if (clr_drop[j]) begin
          out_drop[j] <= 1'b0;
        end
      end
    end
  end

endmodule
